pipe_stage_bank: RTL and testbench

Parametrised successor to the fixed-width MEM/WB-style pipeline register. It holds DEPTH back-to-back stages of DATA_W-bit payload, each with its own valid bit. Each stage supports global freeze, full flush and per-stage kill (bubble insertion). It sits between any two pipeline stages of the processor and replaces hand-instantiated flop arrays. It also exposes occupancy so hazard logic can see in-flight instructions.

---
 rtl/pipe_stage_bank.sv | 117 +++++++++++
 tb/tb_pipe_stage_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: DEPTH back-to-back pipeline register stages with per-stage
// valid bits, global freeze, synchronous flush, per-stage kill and occupancy
// decode for hazard logic.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds a 16-bit saturating
// count of edges spent frozen while holding a valid output (stall_cnt).
module pipe_stage_bank #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 1,
  parameter int ZERO_BUBBLES = 1
) (
  input  logic                         clk,
  input  logic                         global_rst,
  input  logic                         local_clr,
  input  logic                         freeze,
  input  logic [DEPTH-1:0]             kill_mask,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         empty,
  output logic                         full
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_nxt;
  logic [DATA_W-1:0] d_q   [DEPTH];
  logic [DATA_W-1:0] d_nxt [DEPTH];
  logic [OCC_W-1:0]  occ_sum;

  // Source feeding each stage on advance: stage 0 from the input port,
  // every later stage from its predecessor.
  wire [DEPTH-1:0]  src_v;
  wire [DATA_W-1:0] src_d [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_src
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = v_q[i-1];
      assign src_d[i] = d_q[i-1];
    end
  end

  // Next-state per stage: advance or hold, then bubble zeroing, then kill/flush.
  always_comb begin
    v_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d_nxt[i] = '0;
      if (freeze) begin
        v_nxt[i] = v_q[i];
        d_nxt[i] = d_q[i];
      end else begin
        v_nxt[i] = src_v[i];
        d_nxt[i] = src_d[i];
      end
      if ((ZERO_BUBBLES != 0) && !v_nxt[i]) begin
        d_nxt[i] = '0;
      end
      if (kill_mask[i] || local_clr) begin
        v_nxt[i] = 1'b0;
        d_nxt[i] = '0;
      end
    end
  end

  // Stage registers; global_rst clears everything immediately.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_nxt[i];
      end
    end
  end

  // Population count of the registered valid bits.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(v_q[i]);
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_sum;
  assign empty     = (occ_sum == '0);
  assign full      = (occ_sum == FULL_OCC);

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of edges frozen while the output holds a valid beat.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      stall_cnt <= '0;
    end else if (local_clr) begin
      stall_cnt <= '0;
    end else if (freeze && out_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed bench for pipe_stage_bank: a DEPTH=3 zero-bubble instance and a
// DEPTH=1 instance with ZERO_BUBBLES=0. Stall counter checks are present when
// PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_bank;

  logic        clk = 1'b0;
  logic        rst;

  logic        clr, frz, vin;
  logic [2:0]  kill;
  logic [15:0] din;
  logic        ov, emp, ful;
  logic [15:0] od;
  logic [1:0]  occ;

  logic        clr1, frz1, vin1;
  logic [0:0]  kill1;
  logic [15:0] din1;
  logic        ov1, emp1, ful1;
  logic [15:0] od1;
  logic [0:0]  occ1;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] scnt, scnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_bank #(.DATA_W(16), .DEPTH(3), .ZERO_BUBBLES(1)) dut (
    .clk(clk), .global_rst(rst), .local_clr(clr), .freeze(frz),
    .kill_mask(kill), .in_valid(vin), .in_data(din),
    .out_valid(ov), .out_data(od), .occupancy(occ), .empty(emp), .full(ful)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(scnt)
`endif
  );

  pipe_stage_bank #(.DATA_W(16), .DEPTH(1), .ZERO_BUBBLES(0)) dut1 (
    .clk(clk), .global_rst(rst), .local_clr(clr1), .freeze(frz1),
    .kill_mask(kill1), .in_valid(vin1), .in_data(din1),
    .out_valid(ov1), .out_data(od1), .occupancy(occ1), .empty(emp1), .full(ful1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(scnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] data);
    vin = 1'b1;
    din = data;
    tick();
  endtask

  // Leaves stage 2 = 3333, stage 1 = 2222, stage 0 = 1111, all valid.
  task automatic fill3();
    push(16'h3333);
    push(16'h2222);
    push(16'h1111);
    vin = 1'b0;
    din = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 0; frz = 0; vin = 0; kill = '0; din = '0;
    clr1 = 0; frz1 = 0; vin1 = 0; kill1 = '0; din1 = '0;
    #12;
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ov); end
    n_checks++; if (od !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", od); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    n_checks++; if (emp !== 1'b1 || ful !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", emp, ful); end
`ifdef PIPE_STAGE_STALL_CNT_EN
    n_checks++; if (scnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0000", scnt); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    push(16'hA5A5);
    vin = 1'b0; din = 16'hDEAD;
    n_checks++; if (ov !== 1'b0 || occ !== 2'd1) begin n_fail++; $display("FAIL lat_edge0: got v=%b occ=%0d expected 0/1", ov, occ); end
    tick();
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: got v=%b expected 0", ov); end
    tick();
    n_checks++; if (ov !== 1'b1 || od !== 16'hA5A5) begin n_fail++; $display("FAIL lat_edge2: got %b/%h expected 1/a5a5", ov, od); end
    tick();
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000) begin n_fail++; $display("FAIL lat_bubble: got %b/%h expected 0/0000", ov, od); end
    n_checks++; if (occ !== 2'd0 || emp !== 1'b1) begin n_fail++; $display("FAIL lat_empty: got occ=%0d empty=%b expected 0/1", occ, emp); end
    din = 16'h0000;
  endtask

  task automatic test_freeze();
    fill3();
    n_checks++; if (occ !== 2'd3 || ful !== 1'b1) begin n_fail++; $display("FAIL frz_full: got occ=%0d full=%b expected 3/1", occ, ful); end
    n_checks++; if (ov !== 1'b1 || od !== 16'h3333) begin n_fail++; $display("FAIL frz_pre: got %b/%h expected 1/3333", ov, od); end
    frz = 1'b1; vin = 1'b1; din = 16'h4444;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (ov !== 1'b1 || od !== 16'h3333 || occ !== 2'd3) begin n_fail++; $display("FAIL frz_hold%0d: got %b/%h occ=%0d expected 1/3333 occ=3", k, ov, od, occ); end
    end
    frz = 1'b0; vin = 1'b0; din = 16'h0000;
    tick();
    n_checks++; if (ov !== 1'b1 || od !== 16'h2222 || occ !== 2'd2) begin n_fail++; $display("FAIL frz_out2: got %b/%h occ=%0d expected 1/2222 occ=2", ov, od, occ); end
    tick();
    n_checks++; if (ov !== 1'b1 || od !== 16'h1111) begin n_fail++; $display("FAIL frz_out1: got %b/%h expected 1/1111", ov, od); end
    tick();
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000 || occ !== 2'd0) begin n_fail++; $display("FAIL frz_no4444: got %b/%h occ=%0d expected 0/0000 occ=0", ov, od, occ); end
  endtask

  task automatic test_kill();
    fill3();
    kill = 3'b010; vin = 1'b1; din = 16'h5555;
    tick();
    kill = 3'b000; vin = 1'b0; din = 16'h0000;
    n_checks++; if (ov !== 1'b1 || od !== 16'h2222 || occ !== 2'd2) begin n_fail++; $display("FAIL kill_out: got %b/%h occ=%0d expected 1/2222 occ=2", ov, od, occ); end
    tick();
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000 || occ !== 2'd1) begin n_fail++; $display("FAIL kill_bubble: got %b/%h occ=%0d expected 0/0000 occ=1", ov, od, occ); end
    tick();
    n_checks++; if (ov !== 1'b1 || od !== 16'h5555) begin n_fail++; $display("FAIL kill_next: got %b/%h expected 1/5555", ov, od); end
    tick();
  endtask

  task automatic test_freeze_kill();
    fill3();
    frz = 1'b1; kill = 3'b100;
    tick();
    kill = 3'b000;
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000 || occ !== 2'd2 || ful !== 1'b0) begin n_fail++; $display("FAIL fk_bubble: got %b/%h occ=%0d full=%b expected 0/0000 occ=2 full=0", ov, od, occ, ful); end
    frz = 1'b0;
    tick();
    n_checks++; if (ov !== 1'b1 || od !== 16'h2222) begin n_fail++; $display("FAIL fk_resume: got %b/%h expected 1/2222", ov, od); end
  endtask

  task automatic test_flush();
    fill3();
    frz = 1'b1; clr = 1'b1; vin = 1'b1; din = 16'h7777;
    tick();
    frz = 1'b0; clr = 1'b0; vin = 1'b0; din = 16'h0000;
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000) begin n_fail++; $display("FAIL flush_out: got %b/%h expected 0/0000", ov, od); end
    n_checks++; if (occ !== 2'd0 || emp !== 1'b1) begin n_fail++; $display("FAIL flush_occ: got occ=%0d empty=%b expected 0/1", occ, emp); end
  endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
  task automatic test_stall_cnt();
    n_checks++; if (scnt !== 16'h0) begin n_fail++; $display("FAIL stall_after_clr: got %h expected 0000", scnt); end
    frz = 1'b1;
    tick();
    n_checks++; if (scnt !== 16'h0) begin n_fail++; $display("FAIL stall_no_valid: got %h expected 0000", scnt); end
    frz = 1'b0;
    fill3();
    frz = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (scnt !== 16'd5) begin n_fail++; $display("FAIL stall_5: got %h expected 0005", scnt); end
    kill = 3'b001;
    tick();
    kill = 3'b000;
    for (int k = 0; k < 65528; k++) tick();
    n_checks++; if (scnt !== 16'hFFFE) begin n_fail++; $display("FAIL stall_fffe: got %h expected fffe", scnt); end
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (scnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat: got %h expected ffff", scnt); end
    frz = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (scnt !== 16'h0) begin n_fail++; $display("FAIL stall_clr: got %h expected 0000", scnt); end
  endtask
`endif

  task automatic test_zero_bubbles_off();
    vin1 = 1'b1; din1 = 16'h1234;
    tick();
    n_checks++; if (ov1 !== 1'b1 || od1 !== 16'h1234 || ful1 !== 1'b1) begin n_fail++; $display("FAIL zb0_cap: got %b/%h full=%b expected 1/1234 full=1", ov1, od1, ful1); end
    vin1 = 1'b0; din1 = 16'hABCD;
    tick();
    n_checks++; if (ov1 !== 1'b0 || od1 !== 16'hABCD || emp1 !== 1'b1) begin n_fail++; $display("FAIL zb0_raw: got %b/%h empty=%b expected 0/abcd empty=1", ov1, od1, emp1); end
    frz1 = 1'b1; vin1 = 1'b1; din1 = 16'h9999;
    tick();
    n_checks++; if (ov1 !== 1'b0 || od1 !== 16'hABCD) begin n_fail++; $display("FAIL zb0_hold: got %b/%h expected 0/abcd", ov1, od1); end
    frz1 = 1'b0; kill1 = 1'b1;
    tick();
    kill1 = 1'b0;
    n_checks++; if (ov1 !== 1'b0 || od1 !== 16'h0000) begin n_fail++; $display("FAIL zb0_kill: got %b/%h expected 0/0000", ov1, od1); end
    din1 = 16'h5A5A;
    tick();
    n_checks++; if (ov1 !== 1'b1 || od1 !== 16'h5A5A || occ1 !== 1'b1) begin n_fail++; $display("FAIL zb0_adv: got %b/%h occ=%0d expected 1/5a5a occ=1", ov1, od1, occ1); end
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0; vin1 = 1'b0; din1 = 16'h0000;
    n_checks++; if (ov1 !== 1'b0 || od1 !== 16'h0000) begin n_fail++; $display("FAIL zb0_clr: got %b/%h expected 0/0000", ov1, od1); end
  endtask

  task automatic test_async_reset();
    fill3();
    frz = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ov !== 1'b0 || od !== 16'h0000) begin n_fail++; $display("FAIL arst_out: got %b/%h expected 0/0000", ov, od); end
    n_checks++; if (occ !== 2'd0 || emp !== 1'b1 || ful !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got occ=%0d empty=%b full=%b expected 0/1/0", occ, emp, ful); end
`ifdef PIPE_STAGE_STALL_CNT_EN
    n_checks++; if (scnt !== 16'h0) begin n_fail++; $display("FAIL arst_stall: got %h expected 0000", scnt); end
`endif
    rst = 1'b0;
    frz = 1'b0;
    tick();
    n_checks++; if (ov !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL arst_after: got v=%b occ=%0d expected 0/0", ov, occ); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_freeze();
    test_kill();
    test_freeze_kill();
    test_flush();
`ifdef PIPE_STAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_zero_bubbles_off();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
